// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch front end: controller states, NOP encoding
// and default geometry of the instruction memory and redirect bubble.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR            = 32'h0000_0000;
  localparam int          DEFAULT_MEM_DEPTH    = 256;
  localparam int          DEFAULT_FLUSH_CYCLES = 3;
  localparam int          FLUSH_CNT_W          = 8;

endpackage

// File: rtl/bubble_counter.sv
// Down-counter that times the pipeline bubble after a redirect.
// Loaded with the bubble length, decremented once per flush cycle.
module bubble_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             done_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // The fetch cycle that follows FLUSH is itself the last bubble, so done
  // fires on the decrement that would bring the count down to 1.
  assign done_o = (count_q <= WIDTH'(2));

  // Next count: load wins over decrement; the final decrement clears to zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i) begin
      if (done_o) begin
        count_d = '0;
      end else begin
        count_d = count_q - WIDTH'(1);
      end
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: sequential fetch with a one-deep output
// register, decode back-pressure, redirect bubbles and a terminal HALT.
module fetch_controller
  import cpu_pkg::*;
#(
  parameter int MEM_DEPTH    = DEFAULT_MEM_DEPTH,
  parameter int FLUSH_CYCLES = DEFAULT_FLUSH_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        halted,
  output logic        fault
);

  localparam logic [31:0]            LAST_ADDR  = 32'(MEM_DEPTH - 1);
  localparam logic [31:0]            DEPTH_W    = 32'(MEM_DEPTH);
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_out_q, pc_out_d;
  logic         valid_q, valid_d;
  logic         fault_q, fault_d;
  logic         flush_load_s;
  logic         flush_dec_s;
  logic         flush_done_s;
  logic         last_presented_s;

  bubble_counter #(
    .WIDTH (FLUSH_CNT_W)
  ) u_bubble_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (flush_load_s),
    .load_val_i (FLUSH_LOAD),
    .dec_i      (flush_dec_s),
    .done_o     (flush_done_s)
  );

  // Once the final word is on the output, pc parks on it and only its
  // acceptance can move the machine on (to HALT).
  assign last_presented_s = valid_q && (pc_out_q == LAST_ADDR);

  assign imem_addr   = pc_q;
  assign instr_out   = instr_q;
  assign pc_out      = pc_out_q;
  assign instr_valid = valid_q;
  assign halted      = (state_q == ST_HALT);
  assign fault       = fault_q;

  // Next-state logic; priority is stop, then redirect, then flush/stall/capture.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    valid_d      = valid_q;
    fault_d      = fault_q;
    flush_load_s = 1'b0;
    flush_dec_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        pc_d    = 32'h0000_0000;
        valid_d = 1'b0;
        if (start) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN, ST_FLUSH: begin
        if (stop) begin
          state_d = ST_HALT;
          valid_d = 1'b0;
        end else if (redirect) begin
          valid_d = 1'b0;
          if (redirect_target < DEPTH_W) begin
            pc_d         = redirect_target;
            flush_load_s = 1'b1;
            state_d      = ST_FLUSH;
          end else begin
            fault_d = 1'b1;
            state_d = ST_HALT;
          end
        end else if (state_q == ST_FLUSH) begin
          flush_dec_s = 1'b1;
          if (flush_done_s) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_FLUSH;
          end
        end else if (valid_q && !instr_ready) begin
          state_d = ST_RUN;
        end else if (last_presented_s) begin
          valid_d = 1'b0;
          state_d = ST_HALT;
        end else begin
          instr_d  = imem_instr;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          if (pc_q == LAST_ADDR) begin
            pc_d = pc_q;
          end else begin
            pc_d = pc_q + 32'd1;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
        valid_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= 32'h0000_0000;
      instr_q  <= NOP_INSTR;
      pc_out_q <= 32'h0000_0000;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      fault_q  <= fault_d;
    end
  end

endmodule
